// File: rtl/lsu_uart_pkg.sv
// Shared types and constants for the LSU-side UART access sequencer.
package lsu_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TX_WAIT,
        RX_WAIT,
        RX_POP,
        RESP
    } state_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [1:0] OFF_TX   = 2'd0;
    localparam logic [1:0] OFF_RX   = 2'd1;
    localparam logic [1:0] OFF_STAT = 2'd2;
    localparam logic [1:0] OFF_BRD  = 2'd3;

    localparam logic [31:0] RX_ERR_DATA = 32'hFFFF_FFFF;

    function automatic logic is_mem_op(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/lsu_uart_sequencer_if.sv
// LSU/UART side signals of the sequencer; slave = sequencer, master = environment.
interface lsu_uart_sequencer_if;
    logic [6:0]  opcode;
    logic [31:0] address;
    logic [31:0] data_in;
    logic        tx_full;
    logic        rx_empty;
    logic        rx_full;
    logic [9:0]  rx_data;
    logic        pipe_en;
    logic        tx_push;
    logic [7:0]  tx_data;
    logic        rx_pop;
    logic [15:0] brd;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        timeout_err;

    modport slave (
        input  opcode, address, data_in, tx_full, rx_empty, rx_full, rx_data,
        output pipe_en, tx_push, tx_data, rx_pop, brd, rd_data, rd_valid, timeout_err
    );

    modport master (
        output opcode, address, data_in, tx_full, rx_empty, rx_full, rx_data,
        input  pipe_en, tx_push, tx_data, rx_pop, brd, rd_data, rd_valid, timeout_err
    );
endinterface

// File: rtl/lsu_uart_timeout.sv
// Wait-cycle counter; expire fires on the TIMEOUT-th enabled cycle after a clear.
module lsu_uart_timeout #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    assign expire = en && (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + CW'(1);
    end
endmodule

// File: rtl/lsu_uart_sequencer.sv
// Schedules LSU loads/stores that hit the UART window onto the TX/RX FIFOs,
// stalling the pipeline while a FIFO cannot accept or supply data.
module lsu_uart_sequencer #(
    parameter logic [3:0]  UART_BASE = 4'h8,
    parameter int          TIMEOUT   = 1024,
    parameter logic [15:0] BRD_RESET = 16'd868
) (
    input logic                 clk,
    input logic                 rst,
    lsu_uart_sequencer_if.slave bus
);
    import lsu_uart_pkg::*;

    state_t      state, state_nxt;
    logic [7:0]  tx_byte;
    logic [15:0] brd_q;
    logic [31:0] rd_q, rd_nxt;
    logic        err_q;

    logic        hit, is_store;
    logic [1:0]  off;
    logic        push_c, pop_c, stall_c, brd_we, err_set, rd_ld;
    logic        tmo_clr, tmo_en, tmo_exp;
    logic [7:0]  tx_sel;

    logic unused_bits;
    assign unused_bits = ^{bus.address[27:4], bus.address[1:0], bus.data_in[31:16]};

    lsu_uart_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expire (tmo_exp)
    );

    always_comb begin
        hit       = (bus.address[31:28] == UART_BASE) && is_mem_op(bus.opcode);
        is_store  = (bus.opcode == OPC_STORE);
        off       = bus.address[3:2];
        state_nxt = state;
        push_c    = 1'b0;
        pop_c     = 1'b0;
        stall_c   = 1'b0;
        brd_we    = 1'b0;
        err_set   = 1'b0;
        rd_ld     = 1'b0;
        rd_nxt    = '0;
        tmo_clr   = 1'b0;
        tmo_en    = 1'b0;
        tx_sel    = bus.data_in[7:0];
        unique case (state)
            IDLE: if (hit) begin
                if (is_store) begin
                    case (off)
                        OFF_TX: begin
                            if (!bus.tx_full) begin
                                push_c = 1'b1;
                            end else begin
                                stall_c   = 1'b1;
                                tmo_clr   = 1'b1;
                                state_nxt = TX_WAIT;
                            end
                        end
                        OFF_BRD: brd_we = 1'b1;
                        default: ;
                    endcase
                end else begin
                    // Every UART load spends its request cycle stalled.
                    stall_c = 1'b1;
                    case (off)
                        OFF_RX: begin
                            tmo_clr   = 1'b1;
                            state_nxt = bus.rx_empty ? RX_WAIT : RX_POP;
                        end
                        OFF_STAT: begin
                            rd_ld     = 1'b1;
                            rd_nxt    = {29'b0, bus.rx_full, bus.rx_empty, bus.tx_full};
                            state_nxt = RESP;
                        end
                        OFF_BRD: begin
                            rd_ld     = 1'b1;
                            rd_nxt    = {16'b0, brd_q};
                            state_nxt = RESP;
                        end
                        default: begin
                            rd_ld     = 1'b1;
                            state_nxt = RESP;
                        end
                    endcase
                end
            end
            TX_WAIT: begin
                tmo_en = 1'b1;
                tx_sel = tx_byte;
                // A freed FIFO beats a simultaneous expiry; an abandoned store still retires.
                if (!bus.tx_full) begin
                    push_c    = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_exp) begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            RX_WAIT: begin
                stall_c = 1'b1;
                tmo_en  = 1'b1;
                if (!bus.rx_empty) begin
                    state_nxt = RX_POP;
                end else if (tmo_exp) begin
                    err_set   = 1'b1;
                    rd_ld     = 1'b1;
                    rd_nxt    = RX_ERR_DATA;
                    state_nxt = RESP;
                end
            end
            RX_POP: begin
                stall_c   = 1'b1;
                pop_c     = 1'b1;
                rd_ld     = 1'b1;
                rd_nxt    = {22'b0, bus.rx_data};
                state_nxt = RESP;
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced to their idle values for as long as reset is held.
    assign bus.pipe_en     = rst | ~stall_c;
    assign bus.tx_push     = ~rst & push_c;
    assign bus.tx_data     = (~rst & push_c) ? tx_sel : 8'h00;
    assign bus.rx_pop      = ~rst & pop_c;
    assign bus.rd_valid    = ~rst & (state == RESP);
    assign bus.brd         = brd_q;
    assign bus.rd_data     = rd_q;
    assign bus.timeout_err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx_byte <= '0;
            brd_q   <= BRD_RESET;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == TX_WAIT)
                tx_byte <= bus.data_in[7:0];
            if (brd_we)
                brd_q <= bus.data_in[15:0];
            if (rd_ld)
                rd_q <= rd_nxt;
            if (err_set)
                err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lsu_uart_sequencer.sv
// Directed-plus-random bench for lsu_uart_sequencer against an event-count reference model.
module tb_lsu_uart_sequencer;
    localparam int          TMO  = 8;
    localparam logic [15:0] BRD0 = 16'd868;
    localparam logic [6:0]  LD   = 7'b0000011;
    localparam logic [6:0]  ST   = 7'b0100011;

    logic clk = 1'b0;
    logic rst;

    lsu_uart_sequencer_if bus();

    lsu_uart_sequencer #(.UART_BASE(4'h8), .TIMEOUT(TMO), .BRD_RESET(BRD0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int stalls, pushes, pops, valids, push_cyc, pop_cyc, valid_cyc;
    logic [7:0]  push_byte;
    logic [31:0] rd_seen;
    logic        retired;
    logic [15:0] model_brd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.opcode   = 7'h13;
        bus.address  = 32'h0;
        bus.data_in  = 32'h0;
        bus.tx_full  = 1'b0;
        bus.rx_empty = 1'b1;
        bus.rx_full  = 1'b0;
        bus.rx_data  = 10'h0;
    endtask

    // Hold one request until the pipeline retires it, logging every strobe by cycle.
    // free_at: cycle on which the relevant FIFO becomes ready (-1 = never).
    task automatic run(input logic [6:0] opc, input logic [31:0] addr, input logic [31:0] din,
                       input int free_at, input logic [9:0] rxd);
        stalls = 0; pushes = 0; pops = 0; valids = 0;
        push_cyc = -1; pop_cyc = -1; valid_cyc = -1;
        push_byte = 8'h0; rd_seen = 32'h0; retired = 1'b0;
        bus.opcode = opc; bus.address = addr; bus.data_in = din; bus.rx_data = rxd;
        bus.tx_full  = (free_at != 0);
        bus.rx_empty = (free_at != 0);
        for (int c = 0; c < 64 && !retired; c++) begin
            @(negedge clk);
            if (!bus.pipe_en) stalls++;
            if (bus.tx_push) begin pushes++; push_cyc = c; push_byte = bus.tx_data; end
            if (bus.rx_pop) begin pops++; pop_cyc = c; end
            if (bus.rd_valid) begin valids++; valid_cyc = c; rd_seen = bus.rd_data; end
            retired = bus.pipe_en;
            @(posedge clk); #1;
            if (c + 1 == free_at) begin bus.tx_full = 1'b0; bus.rx_empty = 1'b0; end
            if (pop_cyc == c) bus.rx_empty = 1'b1;
        end
        chk("retire", 32'(retired), 32'd1);
        idle();
    endtask

    initial begin
        logic [7:0]  b;
        logic [9:0]  r;
        logic [15:0] d;
        logic        f;
        int          w;

        // Reset with a blocked UART store on the bus.
        rst = 1'b1;
        idle();
        bus.opcode = ST; bus.address = 32'h8000_0000; bus.tx_full = 1'b1;
        #3;
        chk("rst_pipe_en", 32'(bus.pipe_en), 32'd1);
        chk("rst_tx_push", 32'(bus.tx_push), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_rx_pop", 32'(bus.rx_pop), 32'd0);
        chk("rst_brd", 32'(bus.brd), 32'(BRD0));
        chk("rst_rd_data", bus.rd_data, 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
        model_brd = BRD0;
        idle();
        @(posedge clk); #1;
        rst = 1'b0;

        // TX store, FIFO free.
        run(ST, 32'h8000_0000, 32'h0000_0041, 0, 10'h0);
        chk("tx_fast_push", 32'(pushes), 32'd1);
        chk("tx_fast_byte", 32'(push_byte), 32'h41);
        chk("tx_fast_cyc", 32'(push_cyc), 32'd0);
        chk("tx_fast_stall", 32'(stalls), 32'd0);

        // TX store, FIFO full for 5 cycles.
        run(ST, 32'h8000_0000, 32'h0000_0055, 5, 10'h0);
        chk("tx_wait_stall", 32'(stalls), 32'd5);
        chk("tx_wait_byte", 32'(push_byte), 32'h55);
        chk("tx_wait_cyc", 32'(push_cyc), 32'd5);
        chk("tx_wait_push", 32'(pushes), 32'd1);

        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            w = $urandom_range(0, TMO - 1);
            run(ST, {4'h8, 24'($urandom), 4'h0}, {24'($urandom), b}, w, 10'h0);
            chk("tx_rand_stall", 32'(stalls), 32'(w));
            chk("tx_rand_byte", 32'(push_byte), 32'(b));
            chk("tx_rand_push", 32'(pushes), 32'd1);
        end

        // FIFO frees on the expiry cycle: push wins.
        run(ST, 32'h8000_0000, 32'h0000_00A7, TMO, 10'h0);
        chk("tx_race_push", 32'(pushes), 32'd1);
        chk("tx_race_byte", 32'(push_byte), 32'hA7);
        chk("tx_race_err", 32'(bus.timeout_err), 32'd0);

        // RX load, data arrives after 4 empty cycles.
        run(LD, 32'h8000_0004, 32'h0, 4, 10'h23A);
        chk("rx_pop_cyc", 32'(pop_cyc), 32'd5);
        chk("rx_pops", 32'(pops), 32'd1);
        chk("rx_valid_cyc", 32'(valid_cyc), 32'd6);
        chk("rx_data", rd_seen, 32'h0000_023A);
        chk("rx_stall", 32'(stalls), 32'd6);

        for (int i = 0; i < 4; i++) begin
            r = 10'($urandom);
            w = $urandom_range(0, TMO - 1);
            run(LD, 32'h8000_0004, 32'h0, w, r);
            chk("rx_rand_pop_cyc", 32'(pop_cyc), 32'(w + 1));
            chk("rx_rand_valid_cyc", 32'(valid_cyc), 32'(w + 2));
            chk("rx_rand_data", rd_seen, {22'b0, r});
            chk("rx_rand_pops", 32'(pops), 32'd1);
        end

        // Data arrives on the expiry cycle: pop wins.
        r = 10'($urandom);
        run(LD, 32'h8000_0004, 32'h0, TMO, r);
        chk("rx_race_pops", 32'(pops), 32'd1);
        chk("rx_race_data", rd_seen, {22'b0, r});
        chk("rx_race_err", 32'(bus.timeout_err), 32'd0);

        // Baud divisor write then read back.
        run(ST, 32'h8000_000C, 32'h0000_01B2, 0, 10'h0);
        model_brd = 16'h01B2;
        chk("brd_wr_stall", 32'(stalls), 32'd0);
        chk("brd_value", 32'(bus.brd), 32'(model_brd));
        run(LD, 32'h8000_000C, 32'h0, 0, 10'h0);
        chk("brd_rd_data", rd_seen, {16'b0, model_brd});
        chk("brd_rd_stall", 32'(stalls), 32'd1);
        for (int i = 0; i < 2; i++) begin
            d = 16'($urandom);
            run(ST, 32'h8000_000C, {16'($urandom), d}, 0, 10'h0);
            model_brd = d;
            run(LD, 32'h8000_000C, 32'h0, 0, 10'h0);
            chk("brd_rand_rd", rd_seen, {16'b0, model_brd});
            chk("brd_rand_reg", 32'(bus.brd), 32'(model_brd));
        end

        // Status loads with FIFOs ready and blocked.
        f = 1'($urandom);
        bus.rx_full = f;
        run(LD, 32'h8000_0008, 32'h0, 0, 10'h0);
        chk("stat_ready", rd_seen, {29'b0, f, 1'b0, 1'b0});
        chk("stat_stall", 32'(stalls), 32'd1);
        f = 1'($urandom);
        bus.rx_full = f;
        run(LD, 32'h8000_0008, 32'h0, -1, 10'h0);
        chk("stat_blocked", rd_seen, {29'b0, f, 1'b1, 1'b1});

        // Traffic that must pass untouched.
        run(LD, 32'h1000_0004, 32'h0, 0, 10'h155);
        chk("nonhit_stall", 32'(stalls + pops + valids), 32'd0);
        run(7'h33, 32'h8000_0000, 32'h0000_0077, -1, 10'h0);
        chk("other_opc", 32'(stalls + pushes), 32'd0);
        run(ST, 32'h8000_0004, 32'h0000_0066, -1, 10'h0);
        chk("st_rx_ignored", 32'(stalls + pushes + pops), 32'd0);

        // RX timeout with the FIFO stuck empty.
        run(LD, 32'h8000_0004, 32'h0, -1, 10'h3FF);
        chk("rx_tmo_stall", 32'(stalls), 32'(TMO + 1));
        chk("rx_tmo_pops", 32'(pops), 32'd0);
        chk("rx_tmo_valid_cyc", 32'(valid_cyc), 32'(TMO + 1));
        chk("rx_tmo_data", rd_seen, 32'hFFFF_FFFF);
        chk("rx_tmo_err", 32'(bus.timeout_err), 32'd1);

        // Reset while a store waits on a full TX FIFO.
        bus.opcode = ST; bus.address = 32'h8000_0000; bus.data_in = 32'h0000_0099; bus.tx_full = 1'b1;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_pipe_en", 32'(bus.pipe_en), 32'd1);
        chk("mid_rst_push", 32'(bus.tx_push), 32'd0);
        chk("mid_rst_brd", 32'(bus.brd), 32'(BRD0));
        chk("mid_rst_err", 32'(bus.timeout_err), 32'd0);
        chk("mid_rst_rd_data", bus.rd_data, 32'd0);
        model_brd = BRD0;
        idle();
        @(posedge clk); #1;
        rst = 1'b0;
        pushes = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.tx_push) pushes++;
        end
        chk("post_rst_no_push", 32'(pushes), 32'd0);
        @(posedge clk); #1;

        // TX timeout drops the byte.
        run(ST, 32'h8000_0000, 32'h0000_00C3, -1, 10'h0);
        chk("tx_tmo_push", 32'(pushes), 32'd0);
        chk("tx_tmo_err", 32'(bus.timeout_err), 32'd1);
        chk("tx_tmo_brd", 32'(bus.brd), 32'(model_brd));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
